yutorina_if_stage: RTL and testbench

Instruction fetch stage of the Yutorina pipeline. It owns the fetch program counter and issues word reads to instruction memory over a request/ready handshake. It presents each fetched instruction, with its address, to the decode stage through a registered `if_en_`/`if_pc`/`if_insn` bundle. It takes redirects from decode (`br_taken`/`br_addr`) and from the exception/control unit (`flush`/`new_pc`), and it stalls with the rest of the pipeline.

---
 rtl/yutorina_if_stage_if.sv | 35 +++
 rtl/yutorina_if_stage.sv | 150 +++++++++++++++
 tb/tb_yutorina_if_stage.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/yutorina_if_stage_if.sv
// -----------------------------------------------------------------------------
// yutorina_if_stage_if
// Signal bundle around the Yutorina instruction fetch stage.
//   Pipeline control : stall, flush/new_pc, br_taken/br_addr
//   Memory bus       : imem_rd_ / imem_addr (request), imem_rdy_ / imem_rd_data
//                      (completion, active-low ready)
//   Decode bundle    : if_en_ (active-low valid), if_pc, if_insn
// Modports:
//   master : the fetch stage (drives the memory request and decode bundle)
//   slave  : the environment (pipeline control, memory, decode)
// -----------------------------------------------------------------------------
interface yutorina_if_stage_if;
  logic        stall;
  logic        flush;
  logic [29:0] new_pc;
  logic        br_taken;
  logic [29:0] br_addr;
  logic        imem_rd_;
  logic [29:0] imem_addr;
  logic [31:0] imem_rd_data;
  logic        imem_rdy_;
  logic        if_en_;
  logic [29:0] if_pc;
  logic [31:0] if_insn;

  modport master (
    input  stall, flush, new_pc, br_taken, br_addr, imem_rd_data, imem_rdy_,
    output imem_rd_, imem_addr, if_en_, if_pc, if_insn
  );

  modport slave (
    output stall, flush, new_pc, br_taken, br_addr, imem_rd_data, imem_rdy_,
    input  imem_rd_, imem_addr, if_en_, if_pc, if_insn
  );
endinterface

// File: rtl/yutorina_if_stage.sv
// -----------------------------------------------------------------------------
// yutorina_if_stage
// Instruction fetch stage of the Yutorina pipeline. Owns the fetch PC, issues
// word reads to instruction memory over an active-low request/ready handshake
// and hands each fetched instruction plus its address to decode through a
// registered if_en_/if_pc/if_insn bundle. Redirects come from flush/new_pc
// (highest priority) and br_taken/br_addr; stall freezes the bundle, and an
// instruction that completes during a stall is parked in a one-entry buffer.
// Ports:
//   clk  pipeline clock
//   rst  asynchronous active-high reset
//   bus  yutorina_if_stage_if.master (control, memory bus, decode bundle)
// Parameters:
//   RESET_VECTOR  word address of the first fetch after reset
//   NOP_INSN      value on if_insn while no valid instruction is held
// -----------------------------------------------------------------------------
module yutorina_if_stage #(
  parameter logic [29:0] RESET_VECTOR = 30'h0,
  parameter logic [31:0] NOP_INSN     = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  yutorina_if_stage_if.master        bus
);

  // Request tracker: IDLE = nothing outstanding, WAIT = request outstanding,
  // DROP = request outstanding whose data must be thrown away (redirected).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } req_state_e;

  req_state_e  state, state_nxt;

  logic [29:0] fpc;
  logic [29:0] req_addr;
  logic        hold_valid;
  logic [29:0] hold_pc;
  logic [31:0] hold_insn;

  logic        busy;
  logic        drop;
  logic        redirect;
  logic [29:0] target;
  logic        start_ok;
  logic        complete;
  logic        accept;

  // Redirect decode. A branch only counts when decode holds a real
  // instruction and the pipeline is moving; flush overrides everything.
  always_comb begin
    redirect = bus.flush | (bus.br_taken & ~bus.if_en_ & ~bus.stall);
    target   = bus.flush ? bus.new_pc : bus.br_addr;
    start_ok = ~redirect & ~bus.stall & ~hold_valid;
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (~bus.imem_rd_ & bus.imem_rdy_) state_nxt = S_WAIT;
      S_WAIT: begin
        if (complete)      state_nxt = S_IDLE;
        else if (redirect) state_nxt = S_DROP;
      end
      S_DROP: if (complete) state_nxt = S_IDLE;
      default:              state_nxt = S_IDLE;
    endcase
  end

  // Output logic. While rst is high the bus is forced quiet so memory never
  // sees a request from a half-reset stage.
  always_comb begin
    busy = (state != S_IDLE);
    drop = (state == S_DROP);
    if (rst) begin
      bus.imem_rd_  = 1'b1;
      bus.imem_addr = RESET_VECTOR;
    end else begin
      bus.imem_rd_  = ~(busy | start_ok);
      bus.imem_addr = busy ? req_addr : fpc;
    end
    complete = ~bus.imem_rd_ & ~bus.imem_rdy_;
    accept   = complete & ~drop & ~redirect;
  end

  // Address latched when a multi-cycle request starts, so imem_addr stays put
  // even if fpc is redirected underneath it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      req_addr <= RESET_VECTOR;
    else if ((state == S_IDLE) & ~bus.imem_rd_ & bus.imem_rdy_)
      req_addr <= fpc;
  end

  // Fetch PC, hold buffer and decode bundle.
  // NOTE: the hold buffer is a handful of flops rather than a RAM, so it is
  // reset with everything else and never exposes X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc         <= RESET_VECTOR;
      hold_valid  <= 1'b0;
      hold_pc     <= '0;
      hold_insn   <= NOP_INSN;
      bus.if_en_  <= 1'b1;
      bus.if_pc   <= '0;
      bus.if_insn <= NOP_INSN;
    end else if (redirect) begin
      fpc         <= target;
      hold_valid  <= 1'b0;
      bus.if_en_  <= 1'b1;
      bus.if_insn <= NOP_INSN;
    end else if (bus.stall) begin
      // Bundle frozen; a completing request is parked, not lost.
      if (accept) begin
        hold_valid <= 1'b1;
        hold_pc    <= bus.imem_addr;
        hold_insn  <= bus.imem_rd_data;
        fpc        <= bus.imem_addr + 30'd1;
      end
    end else if (hold_valid) begin
      // No request can be in flight here: starts are blocked while the
      // buffer is full, and the parked completion already cleared busy.
      hold_valid  <= 1'b0;
      bus.if_en_  <= 1'b0;
      bus.if_pc   <= hold_pc;
      bus.if_insn <= hold_insn;
    end else if (accept) begin
      bus.if_en_  <= 1'b0;
      bus.if_pc   <= bus.imem_addr;
      bus.if_insn <= bus.imem_rd_data;
      fpc         <= bus.imem_addr + 30'd1;
    end else begin
      bus.if_en_  <= 1'b1;
      bus.if_insn <= NOP_INSN;
    end
  end

endmodule

// File: tb/tb_yutorina_if_stage.sv
// -----------------------------------------------------------------------------
// tb_yutorina_if_stage
// Directed bench for yutorina_if_stage. A small memory responder returns
// {2'b10, addr} for every word after a programmable number of wait cycles.
// Inputs change 2 time units after each rising edge; registered outputs are
// sampled there, combinational ones 1 unit later.
// -----------------------------------------------------------------------------
module tb_yutorina_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  int   waits;
  int   wcnt;
  int   total;
  int   bad;

  yutorina_if_stage_if bus ();

  yutorina_if_stage #(
    .RESET_VECTOR (30'h0),
    .NOP_INSN     (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {2'b10, a};
  endfunction

  // Memory responder: ready once the request has waited 'waits' cycles.
  // Reset abandons any access in progress.
  always @(posedge clk or posedge rst) begin
    if (rst)                                 wcnt <= 0;
    else if (!bus.imem_rd_ && bus.imem_rdy_) wcnt <= wcnt + 1;
    else                                     wcnt <= 0;
  end

  assign bus.imem_rdy_    = !(!bus.imem_rd_ && (wcnt >= waits));
  assign bus.imem_rd_data = mem_word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    waits = 0;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.new_pc   = '0;
    bus.br_taken = 1'b0;
    bus.br_addr  = '0;

    // Reset values.
    #3;
    check("rst_en",   bus.if_en_,    1);
    check("rst_pc",   bus.if_pc,     0);
    check("rst_insn", bus.if_insn,   NOP);
    check("rst_rd",   bus.imem_rd_,  1);
    check("rst_addr", bus.imem_addr, 0);

    // Zero-wait stream from the reset vector.
    step();
    rst = 1'b0;
    #1;
    check("first_rd",   bus.imem_rd_,  0);
    check("first_addr", bus.imem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("zw_en",   bus.if_en_,   0);
      check("zw_pc",   bus.if_pc,    k);
      check("zw_insn", bus.if_insn,  mem_word(30'(k)));
    end

    // Two wait states: one instruction per three edges, address held.
    waits = 2;
    for (int a = 4; a < 6; a++) begin
      #1;
      check("w2_rd",    bus.imem_rd_,  0);
      check("w2_addr0", bus.imem_addr, a);
      step();
      check("w2_bub1",  bus.if_en_,    1);
      check("w2_addr1", bus.imem_addr, a);
      step();
      check("w2_bub2",  bus.if_en_,    1);
      check("w2_addr2", bus.imem_addr, a);
      step();
      check("w2_en",    bus.if_en_,    0);
      check("w2_pc",    bus.if_pc,     a);
      check("w2_insn",  bus.if_insn,   mem_word(30'(a)));
    end

    // Stall for three cycles while the request at 6 completes.
    step();
    check("st_pre_en", bus.if_en_, 1);
    step();
    bus.stall = 1'b1;
    #1;
    check("st_busy_rd", bus.imem_rd_,  0);
    check("st_addr",    bus.imem_addr, 6);
    step();
    check("st_en1",  bus.if_en_, 1);
    check("st_pc1",  bus.if_pc,  5);
    #1;
    check("st_norq1", bus.imem_rd_, 1);
    step();
    check("st_en2",  bus.if_en_, 1);
    check("st_pc2",  bus.if_pc,  5);
    #1;
    check("st_norq2", bus.imem_rd_, 1);
    step();
    bus.stall = 1'b0;
    check("st_en3",  bus.if_en_, 1);
    check("st_pc3",  bus.if_pc,  5);
    #1;
    check("st_rel_rd", bus.imem_rd_, 1);
    step();
    check("st_hold_en",   bus.if_en_,  0);
    check("st_hold_pc",   bus.if_pc,   6);
    check("st_hold_insn", bus.if_insn, mem_word(30'd6));
    #1;
    check("st_next_rd",   bus.imem_rd_,  0);
    check("st_next_addr", bus.imem_addr, 7);
    step();
    check("st_bub_a", bus.if_en_, 1);
    step();
    check("st_bub_b", bus.if_en_, 1);
    step();
    check("st_next_en", bus.if_en_, 0);
    check("st_next_pc", bus.if_pc,  7);

    // Taken branch with zero-wait memory: one bubble, no fall-through.
    waits = 0;
    step();
    check("pre_br_pc8", bus.if_pc, 8);
    step();
    check("pre_br_pc9", bus.if_pc,  9);
    check("pre_br_en",  bus.if_en_, 0);
    bus.br_taken = 1'b1;
    bus.br_addr  = 30'h100;
    #1;
    check("br_norq", bus.imem_rd_, 1);
    step();
    bus.br_taken = 1'b0;
    check("br_bub_en",   bus.if_en_,   1);
    check("br_bub_insn", bus.if_insn,  NOP);
    step();
    check("br_tgt_en",   bus.if_en_,   0);
    check("br_tgt_pc",   bus.if_pc,    30'h100);
    check("br_tgt_insn", bus.if_insn,  mem_word(30'h100));
    step();
    check("br_seq_pc",   bus.if_pc,    30'h101);

    // Flush to 0x8, then flush to 0x20 while the 3-wait read of 0x8 is pending.
    bus.flush  = 1'b1;
    bus.new_pc = 30'h8;
    step();
    bus.flush = 1'b0;
    waits = 3;
    check("fl1_en", bus.if_en_, 1);
    step();
    check("fl_pend_en", bus.if_en_, 1);
    bus.flush  = 1'b1;
    bus.new_pc = 30'h20;
    #1;
    check("fl_pend_rd",   bus.imem_rd_,  0);
    check("fl_pend_addr", bus.imem_addr, 30'h8);
    step();
    bus.flush = 1'b0;
    check("fl_drop_en",   bus.if_en_,    1);
    check("fl_drop_addr", bus.imem_addr, 30'h8);
    step();
    check("fl_drop_en2", bus.if_en_, 1);
    step();
    check("fl_discard_en", bus.if_en_, 1);
    waits = 0;
    #1;
    check("fl_new_rd",   bus.imem_rd_,  0);
    check("fl_new_addr", bus.imem_addr, 30'h20);
    step();
    check("fl_new_en",   bus.if_en_,  0);
    check("fl_new_pc",   bus.if_pc,   30'h20);
    check("fl_new_insn", bus.if_insn, mem_word(30'h20));

    // PC wrap at the top of the 30-bit space.
    bus.flush  = 1'b1;
    bus.new_pc = 30'h3FFF_FFFF;
    step();
    bus.flush = 1'b0;
    step();
    check("wrap_top_pc", bus.if_pc,  30'h3FFF_FFFF);
    check("wrap_top_en", bus.if_en_, 0);
    step();
    check("wrap_zero_pc",   bus.if_pc,   0);
    check("wrap_zero_en",   bus.if_en_,  0);
    check("wrap_zero_insn", bus.if_insn, mem_word(30'h0));

    // Simultaneous flush and branch: flush target wins.
    bus.flush    = 1'b1;
    bus.new_pc   = 30'h40;
    bus.br_taken = 1'b1;
    bus.br_addr  = 30'h80;
    step();
    bus.flush    = 1'b0;
    bus.br_taken = 1'b0;
    check("both_bub_en", bus.if_en_, 1);
    step();
    check("both_pc", bus.if_pc,  30'h40);
    check("both_en", bus.if_en_, 0);

    // Branch during stall is ignored; bundle holds and fetch continues.
    bus.stall    = 1'b1;
    bus.br_taken = 1'b1;
    bus.br_addr  = 30'h80;
    #1;
    check("stbr_norq", bus.imem_rd_, 1);
    step();
    bus.stall    = 1'b0;
    bus.br_taken = 1'b0;
    check("stbr_hold_pc", bus.if_pc,  30'h40);
    check("stbr_hold_en", bus.if_en_, 0);
    step();
    check("stbr_seq_pc", bus.if_pc, 30'h41);

    // Reset asserted in the middle of a wait-state request.
    waits = 3;
    step();
    check("rmid_bub", bus.if_en_, 1);
    rst = 1'b1;
    #1;
    check("rmid_en",   bus.if_en_,    1);
    check("rmid_pc",   bus.if_pc,     0);
    check("rmid_insn", bus.if_insn,   NOP);
    check("rmid_rd",   bus.imem_rd_,  1);
    check("rmid_addr", bus.imem_addr, 0);
    rst   = 1'b0;
    waits = 0;
    step();
    check("rmid_rec_en", bus.if_en_, 0);
    check("rmid_rec_pc", bus.if_pc,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
